gated_deserializer: RTL and testbench
=====================================

// Module: gated_deserializer
// PURPOSE
//   Downstream consumer of the gated sampling stage: collects the single-bit samples on its
//   out port, qualified by a per-sample strobe, into WIDTH-bit words.
//   Presents completed words on a valid/ready interface through a one-entry output register.
//   Flags a sticky overflow when a completed word is dropped.
// PARAMETERS
//   WIDTH      8   bits per word; legal range 2..32
//   MSB_FIRST  1   1: first received bit lands in word_data[WIDTH-1]; 0: first bit lands in [0]
// PORTS
//   _clock          in   1      sole clock; all state updates on posedge
//   _reset          in   1      synchronous, active-high reset
//   bit_valid       in   1      bit_in carries a new sample this cycle
//   bit_in          in   1      sample from the gated stage's out
//   word_valid      out  1      word_data holds a completed word
//   word_data       out  WIDTH  completed word; stable while word_valid && !word_ready
//   word_ready      in   1      consumer accepts the word this cycle
//   overflow        out  1      sticky; a completed word was dropped
//   clear_overflow  in   1      clears overflow
//   word_parity     out  1      only with GATED_DESER_PARITY_EN (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (_reset=1 at posedge): word_valid=0, word_data=0, overflow=0, word_parity=0.
//     Also clears the shift register and bit counter, which aborts any partial word.
//     Reset dominates every other input.
//   - Collector FSM, states IDLE (count=0) and COLLECT (1..WIDTH-1):
//     - bit_valid=1 shifts bit_in in at the MSB_FIRST position and increments count.
//     - bit_valid=0 holds all state; gaps of any length are allowed.
//     - On the WIDTH-th bit: count wraps to 0, the FSM returns to IDLE, and the word completes.
//   - Latency: word_valid rises the cycle after the posedge that sampled the final bit.
//   - Output register, states EMPTY and FULL:
//     - Transfer occurs when word_valid && word_ready.
//     - On completion: if EMPTY, or FULL with a transfer this cycle, load the word and stay or
//       become FULL. No bubble.
//     - On completion while FULL with no transfer: drop the new word, set overflow, and leave
//       word_data unchanged.
//     - Transfer with no completion: go to EMPTY, word_valid=0 next cycle; word_data keeps its
//       last value.
//   - word_valid must not drop without a transfer; word_data must not change while
//     word_valid && !word_ready.
//   - overflow: if set and clear_overflow occur in the same cycle, set wins.
//   - word_ready while EMPTY is ignored.
// CONFIGURATION
//   GATED_DESER_PARITY_EN
//     defined: word_parity = XOR of word_data bits; registered alongside word_data and follows
//       the same load/hold rules.
//     undefined: word_parity port absent, no parity logic.
// STRUCTURE
//   - Shared package gated_pkg holds:
//     - collector state encoding (ST_IDLE, ST_COLLECT)
//     - output state encoding (OUT_EMPTY, OUT_FULL)
//     - GATED_WORD_WIDTH default constant, shared with the gate stage's integration top
//   - One sub-module, gated_shift_collector: shift register, counter and collector FSM.
//     Emits word_done plus the assembled word.
//   - Output register, handshake and overflow logic stay in the top module.
// TESTING
//   1. WIDTH=8, MSB_FIRST=1; bits 1,0,1,0,0,1,0,1 on consecutive cycles, word_ready=1
//      -> word_data=8'hA5, word_valid=1 for exactly one cycle, starting the cycle after bit 8.
//   2. MSB_FIRST=0, same bits with random 0-3 cycle gaps in bit_valid -> word_data=8'hA5,
//      overflow=0.
//   3. word_ready=0; send 16 bits 8'h3C then 8'hFF -> word_data stays 8'h3C, overflow=1 after
//      the 2nd completion. Then assert word_ready -> one transfer of 8'h3C.
//      Then clear_overflow -> overflow=0.
//   4. FULL with 8'h11; complete 8'h22 in the same cycle as word_ready=1
//      -> 8'h11 accepted, 8'h22 presented next cycle, word_valid never drops, overflow=0.
//   5. Send 5 bits, pulse _reset, then 8 bits of 8'hC3 -> word_data=8'hC3; no fragment of the
//      aborted word appears.
//   6. With GATED_DESER_PARITY_EN: words 8'hA5, 8'h07 -> word_parity=0, 1.

Source files
------------

// File: rtl/gated_pkg.sv
// Shared types and constants for the gated sampling chain: collector and output-register
// state encodings plus the default word width used by the integration top.
package gated_pkg;

  localparam int GATED_WORD_WIDTH = 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } coll_state_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/gated_shift_collector.sv
// Shift register, bit counter and collector FSM; word_done pulses combinationally on the
// cycle whose posedge samples the final bit, with word carrying the assembled value.
module gated_shift_collector
  import gated_pkg::*;
#(
  parameter int WIDTH     = GATED_WORD_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             word_done,
  output logic [WIDTH-1:0] word
);

  localparam int CW = $clog2(WIDTH);

  coll_state_t      state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;

  // shifted is the register contents with bit_in already inserted at the entry end
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST != 0) begin : g_msb
        if (gi == 0) begin : g_entry
          assign shifted[gi] = bit_in;
        end else begin : g_move
          assign shifted[gi] = shift_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_entry
          assign shifted[gi] = bit_in;
        end else begin : g_move
          assign shifted[gi] = shift_reg[gi+1];
        end
      end
    end
  endgenerate

  assign last_bit = (state_reg == ST_COLLECT) && (count_reg == CW'(WIDTH - 1));
  assign word     = shifted;

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    shift_next = shift_reg;
    word_done  = 1'b0;
    if (bit_valid) begin
      shift_next = shifted;
      if (last_bit) begin
        count_next = '0;
        state_next = ST_IDLE;
        word_done  = 1'b1;
      end else begin
        count_next = count_reg + CW'(1);
        state_next = ST_COLLECT;
      end
    end
  end

endmodule

// File: rtl/gated_deserializer.sv
// Collects strobed bits into WIDTH-bit words behind a one-entry valid/ready register with a
// sticky overflow flag. Optional word_parity output enabled by GATED_DESER_PARITY_EN.
module gated_deserializer
  import gated_pkg::*;
#(
  parameter int WIDTH     = GATED_WORD_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             word_valid,
  output logic [WIDTH-1:0] word_data,
  input  logic             word_ready,
  output logic             overflow,
  input  logic             clear_overflow
`ifdef GATED_DESER_PARITY_EN
  ,
  output logic             word_parity
`endif
);

  logic             word_done;
  logic [WIDTH-1:0] word;

  gated_shift_collector #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_collector (
    ._clock    (_clock),
    ._reset    (_reset),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .word_done (word_done),
    .word      (word)
  );

  out_state_t       out_state_reg, out_state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             overflow_reg, overflow_next;
  logic             transfer;
  logic             load;
  logic             drop;

  assign transfer = (out_state_reg == OUT_FULL) && word_ready;

  always_ff @(posedge _clock) begin
    if (_reset) begin
      out_state_reg <= OUT_EMPTY;
      data_reg      <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      out_state_reg <= out_state_next;
      data_reg      <= data_next;
      overflow_reg  <= overflow_next;
    end
  end

  always_comb begin
    out_state_next = out_state_reg;
    data_next      = data_reg;
    overflow_next  = overflow_reg;
    load           = 1'b0;
    drop           = 1'b0;
    if (word_done) begin
      // a same-cycle transfer frees the slot, so the new word loads without a bubble
      if (out_state_reg == OUT_EMPTY || transfer) begin
        load           = 1'b1;
        data_next      = word;
        out_state_next = OUT_FULL;
      end else begin
        drop = 1'b1;
      end
    end else if (transfer) begin
      out_state_next = OUT_EMPTY;
    end
    if (clear_overflow) overflow_next = 1'b0;
    if (drop)           overflow_next = 1'b1;
  end

  assign word_valid = (out_state_reg == OUT_FULL);
  assign word_data  = data_reg;
  assign overflow   = overflow_reg;

`ifdef GATED_DESER_PARITY_EN
  logic parity_reg;

  always_ff @(posedge _clock) begin
    if (_reset) begin
      parity_reg <= 1'b0;
    end else if (load) begin
      parity_reg <= ^word;
    end
  end

  assign word_parity = parity_reg;
`endif

endmodule

// File: tb/tb_gated_deserializer.sv
// Self-checking bench for gated_deserializer: MSB-first and LSB-first instances share
// stimulus and are compared against a queue-based word model.
module tb_gated_deserializer;
  import gated_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, bv, bi, rdy, clr;
  logic wv_m, wv_l, ov_m, ov_l;
  logic [W-1:0] wd_m, wd_l;
`ifdef GATED_DESER_PARITY_EN
  logic par_m, par_l;
`endif

  gated_deserializer #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    ._clock(clk), ._reset(rst), .bit_valid(bv), .bit_in(bi),
    .word_valid(wv_m), .word_data(wd_m), .word_ready(rdy),
    .overflow(ov_m), .clear_overflow(clr)
`ifdef GATED_DESER_PARITY_EN
    , .word_parity(par_m)
`endif
  );

  gated_deserializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    ._clock(clk), ._reset(rst), .bit_valid(bv), .bit_in(bi),
    .word_valid(wv_l), .word_data(wd_l), .word_ready(rdy),
    .overflow(ov_l), .clear_overflow(clr)
`ifdef GATED_DESER_PARITY_EN
    , .word_parity(par_l)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model: index 0 = MSB-first instance, 1 = LSB-first instance
  int       bit_q[$];
  logic     mv[2];
  logic [W-1:0] md[2];
  logic     mo[2];

  // one clock of stimulus; model updated from the pre-edge view, outputs sampled at +1
  task automatic cycle(input logic b_v, input logic b, input logic r, input logic c,
                       input logic rs);
    logic done;
    logic [W-1:0] w[2];
    logic xfer;
    bv = b_v; bi = b; rdy = r; clr = c; rst = rs;
    @(posedge clk);
    if (rs) begin
      bit_q.delete();
      for (int k = 0; k < 2; k++) begin
        mv[k] = 1'b0; md[k] = '0; mo[k] = 1'b0;
      end
    end else begin
      done = 1'b0;
      w[0] = '0; w[1] = '0;
      if (b_v) begin
        bit_q.push_back(int'(b));
        if (bit_q.size() == W) begin
          done = 1'b1;
          for (int i = 0; i < W; i++) begin
            if (bit_q[i] != 0) begin
              w[0] = w[0] + W'(1 << (W - 1 - i));
              w[1] = w[1] + W'(1 << i);
            end
          end
          bit_q.delete();
        end
      end
      for (int k = 0; k < 2; k++) begin
        xfer = mv[k] && r;
        if (xfer) $display("xfer inst=%0d data=%h", k, md[k]);
        if (c) mo[k] = 1'b0;
        if (done) begin
          if (!mv[k] || xfer) begin
            md[k] = w[k]; mv[k] = 1'b1;
          end else begin
            mo[k] = 1'b1;
          end
        end else if (xfer) begin
          mv[k] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] val, input logic r, input int max_gap);
    for (int i = W - 1; i >= 0; i--) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, r, 1'b0, 1'b0);
      cycle(1'b1, val[i], r, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    bv = 0; bi = 0; rdy = 0; clr = 0; rst = 1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (wv_m !== 1'b0 || wv_l !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b/%b want 0/0", wv_m, wv_l);
    end
    n_checks++;
    if (wd_m !== 8'h00 || wd_l !== 8'h00) begin
      n_fail++; $display("FAIL reset_data got %h/%h want 00/00", wd_m, wd_l);
    end
    n_checks++;
    if (ov_m !== 1'b0 || ov_l !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow got %b/%b want 0/0", ov_m, ov_l);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_msb_basic();
    logic [W-1:0] pat;
    pat = 8'hA5;
    for (int i = W - 1; i >= 0; i--) begin
      cycle(1'b1, pat[i], 1'b1, 1'b0, 1'b0);
      if (i != 0) begin
        n_checks++;
        if (wv_m !== 1'b0) begin
          n_fail++; $display("FAIL basic_early_valid bit=%0d got %b want 0", W - 1 - i, wv_m);
        end
      end
    end
    n_checks++;
    if (wv_m !== 1'b1 || wd_m !== 8'hA5) begin
      n_fail++; $display("FAIL basic_word got v=%b d=%h want v=1 d=a5", wv_m, wd_m);
    end
    $display("word inst=msb data=%h", wd_m);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (wv_m !== 1'b0) begin
      n_fail++; $display("FAIL basic_one_cycle got v=%b want 0", wv_m);
    end
  endtask

  task automatic test_gaps();
    send_word(8'hA5, 1'b0, 3);
    n_checks++;
    if (wv_l !== 1'b1 || wd_l !== 8'hA5 || ov_l !== 1'b0) begin
      n_fail++; $display("FAIL gaps_lsb got v=%b d=%h o=%b want v=1 d=a5 o=0", wv_l, wd_l, ov_l);
    end
    $display("word inst=lsb data=%h", wd_l);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    send_word(8'h3C, 1'b0, 0);
    n_checks++;
    if (ov_m !== 1'b0) begin
      n_fail++; $display("FAIL ovf_early got %b want 0", ov_m);
    end
    send_word(8'hFF, 1'b0, 0);
    n_checks++;
    if (wd_m !== 8'h3C || wv_m !== 1'b1 || ov_m !== 1'b1) begin
      n_fail++; $display("FAIL ovf_hold got v=%b d=%h o=%b want v=1 d=3c o=1", wv_m, wd_m, ov_m);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (wv_m !== 1'b0 || wd_m !== 8'h3C) begin
      n_fail++; $display("FAIL ovf_drain got v=%b d=%h want v=0 d=3c", wv_m, wd_m);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (ov_m !== 1'b0 || ov_l !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear got %b/%b want 0/0", ov_m, ov_l);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] nxt;
    send_word(8'h11, 1'b0, 0);
    nxt = 8'h22;
    for (int i = W - 1; i >= 0; i--) begin
      cycle(1'b1, nxt[i], (i == 0), 1'b0, 1'b0);
      n_checks++;
      if (wv_m !== 1'b1) begin
        n_fail++; $display("FAIL b2b_valid_drop bit=%0d got %b want 1", W - 1 - i, wv_m);
      end
    end
    n_checks++;
    if (wd_m !== 8'h22 || ov_m !== 1'b0) begin
      n_fail++; $display("FAIL b2b_word got d=%h o=%b want d=22 o=0", wd_m, ov_m);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_word(8'hC3, 1'b1, 0);
    n_checks++;
    if (wv_m !== 1'b1 || wd_m !== 8'hC3) begin
      n_fail++; $display("FAIL abort_word got v=%b d=%h want v=1 d=c3", wv_m, wd_m);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (wv_m !== 1'b0 || wv_l !== 1'b0) begin
      n_fail++; $display("FAIL abort_fragment got v=%b/%b want 0/0", wv_m, wv_l);
    end
  endtask

`ifdef GATED_DESER_PARITY_EN
  task automatic test_parity();
    send_word(8'hA5, 1'b1, 0);
    n_checks++;
    if (par_m !== 1'b0) begin
      n_fail++; $display("FAIL parity_a5 got %b want 0", par_m);
    end
    send_word(8'h07, 1'b1, 0);
    n_checks++;
    if (par_m !== 1'b1) begin
      n_fail++; $display("FAIL parity_07 got %b want 1", par_m);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      cycle(($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 120) == 0));
      n_checks++;
      if (wv_m !== mv[0] || wd_m !== md[0] || ov_m !== mo[0]) begin
        n_fail++;
        $display("FAIL rand_msb t=%0d got v=%b d=%h o=%b want v=%b d=%h o=%b",
                 t, wv_m, wd_m, ov_m, mv[0], md[0], mo[0]);
      end
      n_checks++;
      if (wv_l !== mv[1] || wd_l !== md[1] || ov_l !== mo[1]) begin
        n_fail++;
        $display("FAIL rand_lsb t=%0d got v=%b d=%h o=%b want v=%b d=%h o=%b",
                 t, wv_l, wd_l, ov_l, mv[1], md[1], mo[1]);
      end
`ifdef GATED_DESER_PARITY_EN
      n_checks++;
      if (par_m !== (^md[0]) || par_l !== (^md[1])) begin
        n_fail++; $display("FAIL rand_parity t=%0d got %b/%b want %b/%b",
                           t, par_m, par_l, ^md[0], ^md[1]);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_msb_basic();
    test_gaps();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
`ifdef GATED_DESER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
